// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage / DMA loader) for a 256x8 single-port data memory.
// Optional stall statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int unsigned MAX_WAIT  = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic [7:0]  cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic        dma_burst,
    input  logic [7:0]  dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic [7:0]  dma_rdata,
    output logic        dma_rvalid,
`ifdef DMEM_ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] stall_count,
`endif
    output logic [7:0]  mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        DMA_BURST = 2'd1,
        CPU_TURN  = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);
    localparam logic [3:0] BURST_MAX_C = 4'(BURST_MAX);
    localparam bit         BURST_EN    = (BURST_MAX > 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  dma_rdata_q, dma_rdata_d;
    logic        dma_rvalid_q, dma_rvalid_d;

    always_comb begin
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (!rst) begin
            unique case (state_q)
                ARB: begin
                    if (dma_req && (wait_cnt_q == MAX_WAIT_C)) begin
                        dma_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt = 1'b1;
                    end
                    if (dma_gnt && dma_burst && BURST_EN) begin
                        state_d    = DMA_BURST;
                        beat_cnt_d = 4'd1;
                    end
                end
                DMA_BURST: begin
                    dma_gnt = dma_req;
                    if (dma_req) begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                    // beat_cnt_d already counts the current beat, so BURST_MAX beats total
                    if (!dma_req || !dma_burst || (beat_cnt_d == BURST_MAX_C)) begin
                        state_d = CPU_TURN;
                    end
                end
                CPU_TURN: begin
                    if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt = 1'b1;
                    end
                    state_d = ARB;
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dma_req || dma_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_we    = 1'b0;
        mem_wdata = cpu_wdata;
        if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_we    = dma_we;
            mem_wdata = dma_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end

    always_comb begin
        dma_rvalid_d = dma_gnt & ~dma_we;
        dma_rdata_d  = dma_rvalid_d ? mem_rdata : dma_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB;
            wait_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            dma_rvalid_q <= 1'b0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            dma_rvalid_q <= dma_rvalid_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    assign cpu_stall  = cpu_req & ~cpu_gnt;
    assign cpu_rdata  = mem_rdata;
    assign dma_rdata  = dma_rdata_q;
    assign dma_rvalid = dma_rvalid_q;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stats_clr) begin
            stall_count_d = '0;
        end else if (cpu_stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter in front of the single-port 8-bit data memory: asynchronous read, synchronous write, 256 x 8.
- Requester 0 is the pipeline MEM stage (cpu_*), which by default has priority and sees read data in the same cycle.
- Requester 1 is the DMA/debug loader (dma_*), which gets a starvation guarantee, optional bursts and registered read data.
- Drives the memory's read_addr, write_enable, write_addr and write_data; asserts cpu_stall to freeze the pipeline when the CPU loses arbitration.

Parameters:
MAX_WAIT, 4, consecutive denied DMA cycles before a forced DMA grant (1..15)
BURST_MAX, 8, maximum consecutive DMA beats in one burst (1..15)

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous reset, active-high
cpu_req  input  1  CPU requests an access this cycle
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  8  CPU address
cpu_wdata  input  8  CPU write data
cpu_gnt  output  1  CPU access performed this cycle (combinational)
cpu_stall  output  1  cpu_req & ~cpu_gnt
cpu_rdata  output  8  mem_rdata passed through combinationally
dma_req  input  1  DMA requests an access
dma_we  input  1  1 = write, 0 = read
dma_burst  input  1  DMA asks to keep ownership after this beat
dma_addr  input  8  DMA address
dma_wdata  input  8  DMA write data
dma_gnt  output  1  DMA access performed this cycle (combinational)
dma_rdata  output  8  registered read data of last granted DMA read
dma_rvalid  output  1  1-cycle pulse, cycle after a granted DMA read
mem_addr  output  8  to memory read_addr and write_addr
mem_we  output  1  to memory write_enable
mem_wdata  output  8  to memory write_data
mem_rdata  input  8  from memory read_data

Behaviour:
- Interface fixed: one clock clk; rst synchronous, active-high.
- While rst=1:
  - Outputs: cpu_gnt=0, dma_gnt=0, mem_we=0, cpu_stall=cpu_req.
  - At the clock edge: state<=ARB, wait_cnt<=0, beat_cnt<=0, dma_rvalid<=0, dma_rdata<=0.
- Reset mid-burst or mid-wait: both are abandoned; arbitration restarts from ARB.
- At most one grant per cycle.
- Memory mux: mem_addr/mem_we/mem_wdata come from the granted port. With no grant, mem_we=0 and mem_addr=cpu_addr.
- A granted write is committed at the same posedge. A granted read is valid on mem_rdata in the same cycle.
- States, registered (grant is combinational from state plus current requests):
  - ARB:
    - Force condition: dma_req & (wait_cnt==MAX_WAIT) -> dma_gnt.
    - Otherwise: cpu_req -> cpu_gnt; otherwise dma_req -> dma_gnt.
    - A DMA grant with dma_burst=1 and BURST_MAX>1 -> DMA_BURST, beat_cnt<=1.
  - DMA_BURST:
    - dma_gnt=dma_req; cpu_gnt=0.
    - On each granted beat, beat_cnt increments.
    - Exit to CPU_TURN when dma_req=0, dma_burst=0 on a granted beat, or beat_cnt reaches BURST_MAX.
  - CPU_TURN:
    - Lasts exactly one cycle.
    - cpu_req -> cpu_gnt; otherwise dma_req -> dma_gnt, with no burst entry.
    - Next state is ARB.
- wait_cnt (4 bits):
  - Increments when dma_req & ~dma_gnt, saturating at MAX_WAIT.
  - Clears when dma_gnt=1 or dma_req=0.
- dma_rdata/dma_rvalid: on a cycle with dma_gnt & ~dma_we, dma_rdata<=mem_rdata and dma_rvalid<=1 next cycle; otherwise dma_rvalid<=0.
- Requesters hold req/we/addr/wdata stable until granted. A dropped request is simply not serviced.
- Same-address CPU and DMA requests in the same cycle get no special handling; they are serialised by the grant order.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined:
  - Adds output stall_count (16 bits).
  - Counts cycles with cpu_stall=1, saturating at 16'hFFFF.
  - Cleared by rst.
  - Adds input stats_clr (1 bit), which synchronously zeroes the count and has priority over increment.
- When not defined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- CPU-only traffic:
  - CPU write 0x5A to 0x10, then CPU read of 0x10 -> cpu_gnt=1 both cycles, cpu_rdata=0x5A in the read cycle, cpu_stall=0.
- Simultaneous single requests:
  - cpu_req and dma_req (no burst) both held, MAX_WAIT=4 -> CPU granted 4 cycles, DMA forced on the 5th (cpu_stall=1 that cycle).
  - Pattern repeats; wait_cnt clears after each forced grant.
- DMA burst:
  - dma_burst=1, writes 0x01..0x0A to 0x20..0x29, cpu_req held -> dma_gnt for exactly 8 beats.
  - Then one CPU_TURN cycle with cpu_gnt=1, then the remaining 2 beats via ARB.
  - mem[0x27]=0x08.
- DMA read:
  - DMA read of 0x27 granted in cycle N -> dma_rvalid=1 and dma_rdata=0x08 in cycle N+1 only.
- Reset during burst:
  - rst=1 for one cycle after beat 3 -> grants 0 and mem_we=0 during rst.
  - Next cycle, with CPU requesting, cpu_gnt=1 (state ARB, wait_cnt=0).
- Stats (DMEM_ARB_STATS_EN defined):
  - 6 stall cycles -> stall_count=6.
  - stats_clr asserted during a stall cycle -> 0 next cycle.
